// File: rtl/main_memory.sv
// Main-memory backing store: fixed-latency line reads, one read and one write per cycle,
// self-clearing array after reset, responses returned through a LATENCY-deep shift pipeline.
module main_memory #(
    parameter int LATENCY = 3,
    parameter int LINES   = 256,
    parameter int OFFSET  = 4,
    parameter int PPTR_W  = 32,
    parameter int CL_W    = 8 * (1 << OFFSET)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req_ren,
    input  logic [PPTR_W-1:0] mem_req_raddr,
    input  logic              mem_req_wen,
    input  logic [PPTR_W-1:0] mem_req_waddr,
    input  logic [CL_W-1:0]   mem_req_wcacheline,
    output logic              mem_rec_en,
    output logic [PPTR_W-1:0] mem_rec_addr,
    output logic [CL_W-1:0]   mem_rec_cacheline,
    output logic              mem_ready,
    output logic              dropped,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);
    localparam int IDX_W = $clog2(LINES);

    typedef enum logic {INIT, RUN} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       ptr;
    logic [CL_W-1:0]        mem [LINES];

    logic [IDX_W-1:0]       ridx, widx;
    logic                   rd_acc, wr_acc;
    logic [CL_W-1:0]        rd_data;
    logic                   unused_waddr_bits;

    logic [LATENCY-1:0]             vld_pipe;
    logic [LATENCY-1:0][PPTR_W-1:0] addr_pipe;
    logic [LATENCY-1:0][CL_W-1:0]   data_pipe;

    assign ridx   = mem_req_raddr[OFFSET +: IDX_W];
    assign widx   = mem_req_waddr[OFFSET +: IDX_W];
    assign rd_acc = (state == RUN) && mem_req_ren;
    assign wr_acc = (state == RUN) && mem_req_wen;
    // Only the index field of the write address matters; higher bits alias by design.
    assign unused_waddr_bits = ^mem_req_waddr;

    // Same-index write at the same edge wins over the stored line.
    assign rd_data = (wr_acc && widx == ridx) ? mem_req_wcacheline : mem[ridx];

    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[ptr] <= '0;
        else if (mem_req_wen)
            mem[widx] <= mem_req_wcacheline;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            ptr       <= '0;
            mem_ready <= 1'b0;
            dropped   <= 1'b0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            case (state)
                INIT: begin
                    ptr <= ptr + 1'b1;
                    if (mem_req_ren || mem_req_wen)
                        dropped <= 1'b1;
                    if (ptr == IDX_W'(LINES - 1)) begin
                        state     <= RUN;
                        mem_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (rd_acc && rd_count != 32'hFFFF_FFFF)
                        rd_count <= rd_count + 32'd1;
                    if (wr_acc && wr_count != 32'hFFFF_FFFF)
                        wr_count <= wr_count + 32'd1;
                end
                default: state <= INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
            data_pipe <= '0;
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
                data_pipe[i] <= data_pipe[i-1];
            end
            vld_pipe[0]  <= rd_acc;
            addr_pipe[0] <= mem_req_raddr;
            data_pipe[0] <= rd_data;
        end
    end

    assign mem_rec_en        = vld_pipe[LATENCY-1];
    assign mem_rec_addr      = addr_pipe[LATENCY-1];
    assign mem_rec_cacheline = data_pipe[LATENCY-1];

endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory: init timing, latency, bypass, ordering, aliasing, reset.
module tb_main_memory;
    localparam int PPTR_W = 32;
    localparam int CL_W   = 128;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_req_ren;
    logic [PPTR_W-1:0] mem_req_raddr;
    logic              mem_req_wen;
    logic [PPTR_W-1:0] mem_req_waddr;
    logic [CL_W-1:0]   mem_req_wcacheline;
    logic              mem_rec_en;
    logic [PPTR_W-1:0] mem_rec_addr;
    logic [CL_W-1:0]   mem_rec_cacheline;
    logic              mem_ready;
    logic              dropped;
    logic [31:0]       rd_count, wr_count;

    int n_checks = 0;
    int n_fails  = 0;

    main_memory #(.LATENCY(3), .LINES(256), .OFFSET(4), .PPTR_W(PPTR_W), .CL_W(CL_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_ren(mem_req_ren), .mem_req_raddr(mem_req_raddr),
        .mem_req_wen(mem_req_wen), .mem_req_waddr(mem_req_waddr),
        .mem_req_wcacheline(mem_req_wcacheline),
        .mem_rec_en(mem_rec_en), .mem_rec_addr(mem_rec_addr),
        .mem_rec_cacheline(mem_rec_cacheline),
        .mem_ready(mem_ready), .dropped(dropped),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [CL_W-1:0] got, input logic [CL_W-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [CL_W-1:0] fill(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic wr(input logic [PPTR_W-1:0] a, input logic [CL_W-1:0] d);
        mem_req_wen = 1'b1; mem_req_waddr = a; mem_req_wcacheline = d;
        step();
        mem_req_wen = 1'b0;
    endtask

    // Single read: response must appear exactly in the third cycle after issue, for one cycle.
    task automatic rd_chk(input string tag, input logic [PPTR_W-1:0] a, input logic [CL_W-1:0] d);
        mem_req_ren = 1'b1; mem_req_raddr = a;
        step();
        mem_req_ren = 1'b0;
        step();
        chk({tag, "_early"}, CL_W'(mem_rec_en), CL_W'(1'b0));
        step();
        chk({tag, "_en"}, CL_W'(mem_rec_en), CL_W'(1'b1));
        chk({tag, "_addr"}, CL_W'(mem_rec_addr), CL_W'(a));
        chk({tag, "_data"}, mem_rec_cacheline, d);
        step();
        chk({tag, "_one"}, CL_W'(mem_rec_en), CL_W'(1'b0));
    endtask

    // Counts cycles with mem_ready low after reset release; flags any response seen meanwhile.
    task automatic wait_ready(input bit poke_read, output int cnt, output bit en_seen);
        cnt = 0; en_seen = 1'b0;
        while (!mem_ready && cnt < 1000) begin
            cnt++;
            mem_req_ren   = poke_read && (cnt == 1);
            mem_req_raddr = 32'h40;
            if (mem_rec_en) en_seen = 1'b1;
            step();
        end
        mem_req_ren = 1'b0;
    endtask

    initial begin
        int  cnt;
        bit  en_seen;
        rst_n = 1'b0;
        mem_req_ren = 1'b0; mem_req_raddr = '0;
        mem_req_wen = 1'b0; mem_req_waddr = '0; mem_req_wcacheline = '0;
        repeat (3) step();
        chk("rst_en", CL_W'(mem_rec_en), '0);
        chk("rst_addr", CL_W'(mem_rec_addr), '0);
        chk("rst_data", mem_rec_cacheline, '0);
        chk("rst_ready", CL_W'(mem_ready), '0);
        chk("rst_dropped", CL_W'(dropped), '0);
        chk("rst_rdcnt", CL_W'(rd_count), '0);
        chk("rst_wrcnt", CL_W'(wr_count), '0);

        // Release; a read in the first INIT cycle must be dropped.
        rst_n = 1'b1;
        wait_ready(1'b1, cnt, en_seen);
        chk("init_cycles", CL_W'(cnt), CL_W'(256));
        chk("init_no_rsp", CL_W'(en_seen), '0);
        chk("init_dropped", CL_W'(dropped), CL_W'(1'b1));
        chk("init_rdcnt", CL_W'(rd_count), '0);

        rd_chk("rd40", 32'h40, '0);

        wr(32'h100, fill(8'hA5));
        rd_chk("rd100", 32'h100, fill(8'hA5));

        // Same-edge bypass, then a later write must not disturb the in-flight read.
        mem_req_wen = 1'b1; mem_req_waddr = 32'h200; mem_req_wcacheline = fill(8'h11);
        mem_req_ren = 1'b1; mem_req_raddr = 32'h200;
        step();
        mem_req_ren = 1'b0; mem_req_wcacheline = fill(8'h22);
        step();
        mem_req_wen = 1'b0;
        step();
        chk("byp_en", CL_W'(mem_rec_en), CL_W'(1'b1));
        chk("byp_data", mem_rec_cacheline, fill(8'h11));
        step();
        rd_chk("rd200_new", 32'h200, fill(8'h22));

        // Back-to-back burst of 10 reads.
        for (int i = 0; i < 10; i++) wr(32'(i * 16), fill(8'(8'hC0 + i)));
        for (int i = 0; i < 12; i++) begin
            mem_req_ren = (i < 10); mem_req_raddr = 32'(i * 16);
            step();
            if (i < 2) begin
                chk("burst_pre", CL_W'(mem_rec_en), '0);
            end else begin
                chk("burst_en", CL_W'(mem_rec_en), CL_W'(1'b1));
                chk("burst_addr", CL_W'(mem_rec_addr), CL_W'((i - 2) * 16));
                chk("burst_data", mem_rec_cacheline, fill(8'(8'hC0 + i - 2)));
            end
        end
        mem_req_ren = 1'b0;
        step();
        chk("burst_post", CL_W'(mem_rec_en), '0);

        // Aliasing: 0x1000 maps to line 0; low offset bits are echoed.
        wr(32'h1000, fill(8'hBE));
        rd_chk("alias", 32'h0, fill(8'hBE));
        rd_chk("offset_echo", 32'h10F, fill(8'hA5));

        chk("rd_count", CL_W'(rd_count), CL_W'(16));
        chk("wr_count", CL_W'(wr_count), CL_W'(14));
        chk("dropped_sticky", CL_W'(dropped), CL_W'(1'b1));

        // Reset with a read in flight.
        mem_req_ren = 1'b1; mem_req_raddr = 32'h100;
        step();
        mem_req_ren = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_en", CL_W'(mem_rec_en), '0);
        chk("mrst_rdcnt", CL_W'(rd_count), '0);
        chk("mrst_wrcnt", CL_W'(wr_count), '0);
        chk("mrst_ready", CL_W'(mem_ready), '0);
        chk("mrst_dropped", CL_W'(dropped), '0);
        step();
        rst_n = 1'b1;
        wait_ready(1'b0, cnt, en_seen);
        chk("reinit_cycles", CL_W'(cnt), CL_W'(256));
        chk("reinit_no_rsp", CL_W'(en_seen), '0);
        chk("reinit_dropped", CL_W'(dropped), '0);
        rd_chk("cleared", 32'h100, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/main_memory.md
# main_memory

Main-memory backing store at the far end of the MMU bus. It consumes cache-controller read/write requests after the bus delay line and returns read responses, carrying address and full cacheline, back into that delay line. Access latency is fixed; one read and one write are accepted per cycle. The memory has no backpressure and self-clears its array after reset.

## Interface
- LATENCY, 3: cycles from read acceptance to response; legal range ≥1.
- LINES, 256: number of stored cachelines; power of two.
- OFFSET, 4: byte-offset bits of a cacheline in a `pptr_t`.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- mem_req_ren  in  1  read request valid.
- mem_req_raddr  in  pptr_t  read byte address.
- mem_req_wen  in  1  write request valid.
- mem_req_waddr  in  pptr_t  write byte address.
- mem_req_wcacheline  in  cacheline_t  write data (whole line).
- mem_rec_en  out  1  response valid, one cycle per read.
- mem_rec_addr  out  pptr_t  echo of the accepted read address, unmodified.
- mem_rec_cacheline  out  cacheline_t  read data.
- mem_ready  out  1  high once array init is complete.
- dropped  out  1  sticky: a request arrived while not ready.
- rd_count, wr_count  out  32 each  saturating counts of accepted reads/writes.

## Operation
- Line index = addr[OFFSET +: $clog2(LINES)]; higher address bits ignored (aliasing by design). Low OFFSET bits are ignored for indexing but echoed unchanged in mem_rec_addr.
- FSM states INIT and RUN.
  - Reset enters INIT with clear pointer 0.
  - INIT writes zero to line[ptr] each cycle and increments ptr.
  - After the line LINES-1 write, the FSM moves to RUN.
  - RUN is terminal until the next reset.
- In INIT, all requests are ignored. Any ren or wen sets `dropped`, which stays set until reset. No response is produced for a dropped read.
- In RUN, a write with wen=1 updates line[widx] at the edge.
- In RUN, a read with ren=1 snapshots line data at acceptance. If a write to the same index is accepted at the same edge, the snapshot holds the new write data (write-before-read bypass).
- The snapshot, address and valid enter a LATENCY-deep shift pipeline. Data is not re-read at response time, so writes after acceptance do not affect an in-flight read.
- Responses leave in acceptance order, back-to-back, with no gaps or merging.
- rd_count/wr_count increment by 1 per accepted RUN request and saturate at 0xFFFF_FFFF. Dropped requests are not counted.

## Timing
- A request sampled at edge t (cycle t) produces mem_rec_en=1 during cycle t+LATENCY, with addr and data valid in the same cycle.
- Outputs are registered; no combinational path from inputs to outputs.
- After rst_n rises, mem_ready=0 for exactly LINES cycles, then goes to 1. The first request accepted is one sampled in a cycle with mem_ready=1.
- Reset values:
  - mem_rec_en=0, mem_rec_addr=0, mem_rec_cacheline=0.
  - mem_ready=0, dropped=0, counters=0.
  - Every pipeline valid bit is 0.
- Reset asserted mid-operation:
  - All in-flight responses are discarded; no mem_rec_en appears after reset.
  - Array contents are discarded and INIT restarts from ptr 0.
- Simultaneous read and write to different indices are independent. Simultaneous read and write to the same index are bypassed as described above.
- mem_rec_* when mem_rec_en=0: data/addr hold the last pipeline-stage values; consumers must ignore them.

## Test plan
- Reset release with LINES=256 → mem_ready rises after exactly 256 cycles. A subsequent read of 0x40 returns all-zero data at +LATENCY (3 cycles), with mem_rec_addr=0x40.
- Write 0xA5A5…A5 to 0x100 at cycle t, read 0x100 at t+1 → response at t+4 with data 0xA5…A5. rd_count=1, wr_count=1.
- Write 0x1111…11 and read of 0x200 in the same cycle → response carries 0x1111…11. A write of 0x2222…22 to 0x200 one cycle later does not change that response.
- Reads of 0x000, 0x010, …, 0x090 in 10 consecutive cycles → 10 consecutive mem_rec_en cycles in the same order, each with the matching address and data.
- With OFFSET=4 and LINES=256: write 0xBEEF… to 0x1000, then read 0x0000 → returns 0xBEEF… with mem_rec_addr=0x0000.
- Read during INIT → no response and dropped=1 until reset. Separately, reads in flight then rst_n pulsed low for 1 cycle → mem_rec_en stays 0, counters read 0, and INIT re-runs.
